// File: rtl/fifo_frame_sender_if.sv
// fifo_frame_sender_if: groups the FIFO read port and the framed byte stream
// of fifo_frame_sender.
//   fifo_data/fifo_empty/fifo_read : FWFT FIFO head word, empty flag, pop strobe
//   byte_out/byte_valid/byte_ready : framed byte stream toward the UART
//   busy                           : sender is in the middle of a frame
// master = sender side, slave = FIFO/consumer side.
interface fifo_frame_sender_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_read;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             busy;

  modport master (
    input  fifo_data, fifo_empty, byte_ready,
    output fifo_read, byte_out, byte_valid, busy
  );

  modport slave (
    output fifo_data, fifo_empty, byte_ready,
    input  fifo_read, byte_out, byte_valid, busy
  );
endinterface

// File: rtl/fifo_frame_sender.sv
// fifo_frame_sender: pops one WIDTH-bit word from a first-word-fall-through
// FIFO and sends it as a frame over a valid/ready byte stream:
//   SYNC_BYTE, seq, payload bytes MSB first, checksum (seq + payload, mod 256).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fifo_frame_sender_if.master (FIFO read port, byte stream, busy)
module fifo_frame_sender #(
  parameter int unsigned WIDTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  fifo_frame_sender_if.master bus
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEQ,
    S_DATA,
    S_CHK
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       chk_q, chk_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [7:0]       byte_c;
  logic             valid_c;
  logic             read_c;

  // byte_valid is high in every non-IDLE state, so byte_ready alone marks a
  // handshake inside those states.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    chk_d   = chk_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    byte_c  = '0;
    valid_c = 1'b0;
    read_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.fifo_empty && !rst) begin
          read_c  = 1'b1;
          shift_d = bus.fifo_data;
          chk_d   = '0;
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        valid_c = 1'b1;
        byte_c  = SYNC_BYTE;
        if (bus.byte_ready) state_d = S_SEQ;
      end
      S_SEQ: begin
        valid_c = 1'b1;
        byte_c  = seq_q;
        if (bus.byte_ready) begin
          chk_d   = chk_q + seq_q;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        valid_c = 1'b1;
        byte_c  = shift_q[WIDTH-1 -: 8];
        if (bus.byte_ready) begin
          chk_d   = chk_q + shift_q[WIDTH-1 -: 8];
          shift_d = shift_q << 8;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = S_CHK;
        end
      end
      S_CHK: begin
        valid_c = 1'b1;
        byte_c  = chk_q;
        if (bus.byte_ready) begin
          seq_d   = seq_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      seq_q   <= '0;
      chk_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      chk_q   <= chk_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.fifo_read  = read_c;
  assign bus.byte_out   = byte_c;
  assign bus.byte_valid = valid_c;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_frame_sender.sv
// tb_fifo_frame_sender: randomized bench for fifo_frame_sender (WIDTH=16).
// A queue models the FWFT FIFO; each observed pop builds the whole expected
// frame (sync, seq, payload bytes, checksum) which accepted bytes are
// compared against.
module tb_fifo_frame_sender;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NBYTES = WIDTH / 8;
  localparam logic [7:0]  SYNC   = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_frame_sender_if #(.WIDTH(WIDTH)) bus();

  fifo_frame_sender #(.WIDTH(WIDTH), .SYNC_BYTE(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] fq[$];
  logic [7:0]       exp_q[$];
  logic [7:0]       byte_log[$];
  logic [7:0]       seq_log[$];
  int               rd_log[$];
  int               cyc = 0;
  int               busy_cnt = 0;
  int               frame_acc = 0;
  bit               rand_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor, reference model and FIFO/consumer driver.
  initial begin
    logic rd, v, r, bz;
    logic prev_rd, prev_stall, rst_prev, after_rst;
    logic [7:0] b, prev_b, sum, e, seq_m, bt;
    logic [WIDTH-1:0] w;
    prev_rd = 0; prev_stall = 0; rst_prev = 0; after_rst = 0;
    prev_b = '0; seq_m = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.byte_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      rd = bus.fifo_read; v = bus.byte_valid; r = bus.byte_ready;
      bz = bus.busy;      b = bus.byte_out;
      if (rst) begin
        check_eq("rst_read", rd, 0);
        if (rst_prev) begin
          check_eq("rst_valid", v, 0);
          check_eq("rst_busy", bz, 0);
          check_eq("rst_byte", b, 0);
        end
        exp_q.delete();
        frame_acc = 0; seq_m = '0;
        prev_rd = 0; prev_stall = 0; after_rst = 1;
      end else begin
        if (after_rst) begin
          check_eq("post_rst_valid", v, 0);
          check_eq("post_rst_busy", bz, 0);
          after_rst = 0;
        end
        check_eq("busy", bz, exp_q.size() != 0);
        check_eq("valid", v, exp_q.size() != 0);
        if (bz) begin
          check_eq("read_while_busy", rd, 0);
          busy_cnt++;
        end
        if (prev_rd) check_eq("pop_latency", {v, b}, {1'b1, SYNC});
        if (prev_stall) check_eq("stall_hold", {v, b}, {1'b1, prev_b});
        if (v && r) begin
          if (exp_q.size() == 0) check_eq("unexpected_byte", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            check_eq("byte", b, e);
          end
          byte_log.push_back(b);
          frame_acc++;
          if (frame_acc == 2) seq_log.push_back(b);
          if (frame_acc == int'(NBYTES) + 3) frame_acc = 0;
        end
        if (rd) begin
          if (fq.size() == 0) check_eq("pop_when_empty", fq.size(), 1);
          else begin
            w = fq[0];
            sum = seq_m;
            exp_q.push_back(SYNC);
            exp_q.push_back(seq_m);
            for (int i = 0; i < int'(NBYTES); i++) begin
              bt = w[WIDTH-1-8*i -: 8];
              sum = sum + bt;
              exp_q.push_back(bt);
            end
            exp_q.push_back(sum);
            seq_m = seq_m + 8'd1;
          end
          rd_log.push_back(cyc);
        end
        prev_rd = rd; prev_stall = v && !r; prev_b = b;
      end
      rst_prev = rst;
      @(posedge clk);
      #1;
      if (prev_rd && fq.size() > 0) void'(fq.pop_front());
      if (fq.size() > 0) begin
        bus.fifo_empty = 1'b0;
        bus.fifo_data  = fq[0];
      end else begin
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = WIDTH'($urandom);
      end
      bus.byte_ready = rand_ready ? 1'($urandom) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    tick();
    while ((fq.size() != 0 || exp_q.size() != 0 || bus.busy) && n < budget) begin
      tick();
      n++;
    end
    check_eq("idle_timeout", bus.busy || fq.size() != 0 || exp_q.size() != 0, 0);
  endtask

  task automatic check_log(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0] ex [5];
    ex = '{e0, e1, e2, e3, e4};
    check_eq({tag, "_len"}, byte_log.size(), 5);
    for (int i = 0; i < 5; i++)
      check_eq(tag, (i < byte_log.size()) ? byte_log[i] : 8'hxx, ex[i]);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Single word, ready high
    byte_log.delete(); rd_log.delete(); busy_cnt = 0;
    fq.push_back(16'h1234);
    wait_idle(100);
    check_log("frame_1234", 8'hA5, 8'h00, 8'h12, 8'h34, 8'h46);
    check_eq("pops_1234", rd_log.size(), 1);
    check_eq("busy_cycles", busy_cnt, 5);

    // Checksum truncation
    byte_log.delete();
    fq.push_back(16'hFFFF);
    wait_idle(100);
    check_log("frame_ffff", 8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF);

    // Back-to-back frames
    rd_log.delete(); seq_log.delete();
    for (int i = 0; i < 3; i++) fq.push_back(WIDTH'($urandom));
    wait_idle(200);
    check_eq("b2b_pops", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      check_eq("b2b_period0", rd_log[1] - rd_log[0], NBYTES + 4);
      check_eq("b2b_period1", rd_log[2] - rd_log[1], NBYTES + 4);
    end
    if (seq_log.size() == 3) begin
      check_eq("b2b_seq0", seq_log[0], 8'h02);
      check_eq("b2b_seq1", seq_log[1], 8'h03);
      check_eq("b2b_seq2", seq_log[2], 8'h04);
    end

    // Backpressure
    rand_ready = 1'b1;
    byte_log.delete();
    fq.push_back(16'hBEEF);
    wait_idle(500);
    check_log("frame_beef", 8'hA5, 8'h05, 8'hBE, 8'hEF, 8'hB2);

    // Reset after the SEQ byte is accepted
    rand_ready = 1'b0;
    fq.push_back(16'h5A5A);
    n = 0;
    while (frame_acc != 2 && n < 100) begin
      tick();
      n++;
    end
    check_eq("reach_seq_timeout", frame_acc, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    byte_log.delete();
    wait_idle(100);
    fq.push_back(16'h0102);
    wait_idle(100);
    check_log("frame_after_rst", 8'hA5, 8'h00, 8'h01, 8'h02, 8'h03);

    // Sequence wrap over 257 frames with random backpressure
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rand_ready = 1'b1;
    seq_log.delete();
    for (int i = 0; i < 257; i++) fq.push_back(WIDTH'($urandom));
    wait_idle(20000);
    check_eq("wrap_frames", seq_log.size(), 257);
    if (seq_log.size() == 257) begin
      check_eq("wrap_seq_first", seq_log[0], 8'h00);
      check_eq("wrap_seq_255", seq_log[255], 8'hFF);
      check_eq("wrap_seq_256", seq_log[256], 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
